// File: rtl/jar_sram_pkg.sv
// jar_sram_pkg: shared definitions for the host side of the nibble-serial SRAM tile.
//   - jar_state_e : sequencer state encoding (4-bit)
//   - pin bit indices of the packed tile bus {nibble, oe, we, srst, sclk}
//   - beat counts per operation
//   - pin_word()  : packs the individual pin fields into the 8-bit bus
package jar_sram_pkg;

  typedef enum logic [3:0] {
    ST_INIT_S = 4'd0,
    ST_INIT_P = 4'd1,
    ST_IDLE   = 4'd2,
    ST_W0_S   = 4'd3,
    ST_W0_P   = 4'd4,
    ST_W1_S   = 4'd5,
    ST_W1_P   = 4'd6,
    ST_WA_S   = 4'd7,
    ST_WA_P   = 4'd8,
    ST_RA_S   = 4'd9,
    ST_RA_P   = 4'd10,
    ST_RCAP   = 4'd11
  } jar_state_e;

  localparam int NIB_HI = 7;
  localparam int NIB_LO = 4;
  localparam int OE     = 3;
  localparam int WE     = 2;
  localparam int SRST   = 1;
  localparam int SCLK   = 0;

  // Beats (setup+pulse pairs) driven to the tile per operation.
  localparam int WR_BEATS = 3;
  localparam int RD_BEATS = 1;

  function automatic logic [7:0] pin_word(input logic [3:0] nib, input logic oe,
                                          input logic we, input logic srst,
                                          input logic sclk);
    logic [7:0] w;
    w                 = 8'h00;
    w[NIB_HI:NIB_LO]  = nib;
    w[OE]             = oe;
    w[WE]             = we;
    w[SRST]           = srst;
    w[SCLK]           = sclk;
    return w;
  endfunction

endpackage

// File: rtl/jar_sram_host.sv
// jar_sram_host: turns byte-wide read/write requests into the pin protocol of
// the 8-byte nibble-serial SRAM tile and returns read data.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid/req_ready/req_we/req_addr/req_wdata : request channel
//   rsp_valid    : one-cycle pulse when rsp_rdata carries new read data
//   rsp_rdata    : read data, held until the next read completes
//   sram_io_in   : registered pins to the tile {nibble[7:4], oe, we, srst, sclk}
//   sram_io_out  : tile data output, sampled in RCAP
//   dbg_state    : current sequencer state
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_ready is 1 only while the sequencer is in IDLE.
// Requests presented while req_ready is 0 are ignored, not queued.
//
// Every pin comes straight from a flop whose next value is decoded from the
// next state, so fields change on the same edge that drops sclk (entry to a
// setup state) and stay put through the pulse cycle.
module jar_sram_host
  import jar_sram_pkg::*;
#(
  parameter int AW = 3,
  parameter int DW = 8,
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [7:0]    sram_io_in,
  input  logic [7:0]    sram_io_out,
  output logic [3:0]    dbg_state
);

  jar_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          req_ready_q, req_ready_d;
  logic [7:0]    pins_q, pins_d;
  logic [NW-1:0] nib_addr;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      ST_INIT_S: state_d = ST_INIT_P;
      ST_INIT_P: state_d = ST_IDLE;
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? ST_W0_S : ST_RA_S;
        end
      end
      ST_W0_S:   state_d = ST_W0_P;
      ST_W0_P:   state_d = ST_W1_S;
      ST_W1_S:   state_d = ST_W1_P;
      ST_W1_P:   state_d = ST_WA_S;
      ST_WA_S:   state_d = ST_WA_P;
      ST_WA_P:   state_d = ST_IDLE;
      ST_RA_S:   state_d = ST_RA_P;
      ST_RA_P:   state_d = ST_RCAP;
      ST_RCAP: begin
        rsp_rdata_d = sram_io_out[DW-1:0];
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default:   state_d = ST_INIT_S;
    endcase
  end

  // Pins are decoded from the *next* state and next captured fields so the
  // flop outputs present them in the cycle the state is entered.
  assign nib_addr = NW'(addr_d);

  always_comb begin
    pins_d = pin_word(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    case (state_d)
      ST_INIT_S: pins_d = pin_word(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      ST_INIT_P: pins_d = pin_word(4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      ST_IDLE:   pins_d = 8'h00;
      ST_W0_S:   pins_d = pin_word(wdata_d[NW-1:0],  1'b0, 1'b1, 1'b0, 1'b0);
      ST_W0_P:   pins_d = pin_word(wdata_d[NW-1:0],  1'b0, 1'b1, 1'b0, 1'b1);
      ST_W1_S:   pins_d = pin_word(wdata_d[DW-1:NW], 1'b0, 1'b1, 1'b0, 1'b0);
      ST_W1_P:   pins_d = pin_word(wdata_d[DW-1:NW], 1'b0, 1'b1, 1'b0, 1'b1);
      ST_WA_S:   pins_d = pin_word(nib_addr,         1'b0, 1'b1, 1'b0, 1'b0);
      ST_WA_P:   pins_d = pin_word(nib_addr,         1'b0, 1'b1, 1'b0, 1'b1);
      ST_RA_S:   pins_d = pin_word(nib_addr,         1'b1, 1'b0, 1'b0, 1'b0);
      ST_RA_P:   pins_d = pin_word(nib_addr,         1'b1, 1'b0, 1'b0, 1'b1);
      // RCAP keeps the read address and oe on the bus so the tile output is
      // still valid at the edge that captures it.
      ST_RCAP:   pins_d = pin_word(nib_addr,         1'b1, 1'b0, 1'b0, 1'b0);
      default:   pins_d = pin_word(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endcase
  end

  assign req_ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT_S;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      pins_q      <= 8'h02;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      pins_q      <= pins_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign sram_io_in = pins_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_jar_sram_host.sv
// Bench for jar_sram_host, with a behavioural model of the nibble-serial tile.

// jar_sram_top: tile model. On each sclk rise: srst clears the beat counter;
// with we=1 beats are low nibble, high nibble, address (write on the third);
// with oe=1, we=0 the beat latches the read address. io_out shows the
// addressed byte while oe=1 and we=0.
module jar_sram_top (
  input  logic       io_clk,
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  logic [7:0] mem [8];
  logic [1:0] cnt;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [2:0] raddr;

  always @(posedge io_clk) begin
    if (io_in[1]) begin
      cnt <= 2'd0;
    end else if (io_in[2]) begin
      case (cnt)
        2'd0: begin lo <= io_in[7:4]; cnt <= 2'd1; end
        2'd1: begin hi <= io_in[7:4]; cnt <= 2'd2; end
        default: begin mem[io_in[6:4]] <= {hi, lo}; cnt <= 2'd0; end
      endcase
    end else if (io_in[3]) begin
      raddr <= io_in[6:4];
    end
  end

  assign io_out = (io_in[3] && !io_in[2]) ? mem[raddr] : 8'h00;
endmodule

module tb_jar_sram_host;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [7:0] sram_io_in;
  logic [7:0] sram_io_out;
  logic [3:0] dbg_state;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_mem [8];

  always #5 clk = ~clk;

  jar_sram_host #(.AW(3), .DW(8), .NW(4)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_io_in(sram_io_in), .sram_io_out(sram_io_out),
    .dbg_state(dbg_state)
  );

  jar_sram_top u_tile (
    .io_clk(sram_io_in[0]), .io_in(sram_io_in), .io_out(sram_io_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    check({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(rsp_rdata), 32'(e));
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] ep [7];
    wait_ready("wr_ready");
    ep[0] = {d[3:0], 4'h4};
    ep[1] = {d[3:0], 4'h5};
    ep[2] = {d[7:4], 4'h4};
    ep[3] = {d[7:4], 4'h5};
    ep[4] = {1'b0, a, 4'h4};
    ep[5] = {1'b0, a, 4'h5};
    ep[6] = 8'h00;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0; req_we = 1'b0;
    model_mem[a] = d;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("wr_pin%0d_a%0d", k, a), 32'(sram_io_in), 32'(ep[k]));
      if (k == 5) check("wr_ready_busy", 32'(req_ready), 32'd0);
      if (k == 6) check("wr_ready_done", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic do_read(input logic [2:0] a);
    logic [7:0] base;
    logic [7:0] ep [4];
    wait_ready("rd_ready");
    base  = {1'b0, a, 4'h8};
    ep[0] = base;
    ep[1] = base | 8'h01;
    ep[2] = base;
    ep[3] = 8'h00;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'h00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    exp_q.push_back(model_mem[a]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rd_pin%0d_a%0d", k, a), 32'(sram_io_in), 32'(ep[k]));
      if (k < 3) begin
        check("rd_no_rsp_early", 32'(rsp_valid), 32'd0);
      end else begin
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_with_ready", 32'(req_ready), 32'd1);
        pop_check($sformatf("rd_data_a%0d", a));
      end
    end
    @(negedge clk);
    check("rd_rsp_pulse_one", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int op;
    int last_acc;
    logic prev_we;
    logic got;
    logic [7:0] prev_pins;
    logic [2:0] wa;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;

    // Reset values and INIT beat
    repeat (3) @(negedge clk);
    check("rst_pins", 32'(sram_io_in), 32'h02);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst = 1'b0;
    #1 check("init_s_pins", 32'(sram_io_in), 32'h02);
    @(negedge clk);
    check("init_p_pins", 32'(sram_io_in), 32'h03);
    check("init_p_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("idle_pins", 32'(sram_io_in), 32'h00);
    check("idle_ready", 32'(req_ready), 32'd1);

    // Single write then read
    do_write(3'd5, 8'hA7);
    check("tile_mem5", 32'(u_tile.mem[5]), 32'hA7);
    do_read(3'd5);

    // Fill every address, then read all back
    for (int i = 0; i < 8; i++) do_write(3'(i), 8'(8'h10 + i));
    for (int i = 0; i < 8; i++) do_read(3'(i));

    // Reset in W1_P of a write to addr 2; tile keeps its old contents
    wait_ready("mid_wr_ready");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd2; req_wdata = 8'hE1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_we = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_wr_w1p_pins", 32'(sram_io_in), 32'hE5);
    rst = 1'b1;
    #1 check("mid_wr_rst_pins", 32'(sram_io_in), 32'h02);
    check("mid_wr_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_write(3'd2, 8'h3C);
    check("tile_mem2_resync", 32'(u_tile.mem[2]), 32'h3C);
    do_read(3'd2);

    // Reset during RA_P of a read: no response may follow
    wait_ready("mid_rd_ready");
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("mid_rd_rst_pins", 32'(sram_io_in), 32'h02);
    @(negedge clk);
    rst = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("mid_rd_no_rsp", 32'(got), 32'd0);

    // req_valid held high, alternating write/read of random addr/data
    op = 0; last_acc = -1; prev_we = 1'b0;
    wa = 3'($urandom_range(0, 7));
    req_valid = 1'b1; req_we = 1'b1; req_addr = wa; req_wdata = 8'($urandom_range(0, 255));
    prev_pins = sram_io_in;
    for (int cyc = 0; cyc < 200 && op < 10; cyc++) begin
      @(negedge clk);
      if (sram_io_in[0]) check("b2b_hold_fields", 32'(sram_io_in[7:1]), 32'(prev_pins[7:1]));
      if (rsp_valid) begin
        check("b2b_rsp_with_ready", 32'(req_ready), 32'd1);
        pop_check("b2b_rd_data");
      end
      prev_pins = sram_io_in;
      if (req_ready) begin
        if (last_acc >= 0) check("b2b_acc_gap", 32'(cyc - last_acc), prev_we ? 32'd7 : 32'd4);
        if (req_we) model_mem[req_addr] = req_wdata;
        else exp_q.push_back(model_mem[req_addr]);
        prev_we = req_we; last_acc = cyc; op++;
        @(posedge clk);
        #1;
        if (op >= 10) begin
          req_valid = 1'b0;
        end else if (op % 2 == 1) begin
          req_we = 1'b0;
        end else begin
          wa = 3'($urandom_range(0, 7));
          req_we = 1'b1; req_addr = wa; req_wdata = 8'($urandom_range(0, 255));
        end
      end
    end
    check("b2b_all_accepted", 32'(op), 32'd10);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        pop_check("b2b_last_rd_data");
        got = 1'b1;
      end
    end
    check("b2b_last_rsp_seen", 32'(got), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jar_sram_host.md
# jar_sram_host

Host-side sequencer directly upstream of the 8-byte nibble-serial SRAM tile. It accepts byte-wide read/write requests over a valid/ready handshake. It expands each request into the tile's pin protocol on a single packed 8-bit bus: nibble[7:4], oe[3], we[2], rst[1], strobe clock[0]. It also returns read data on a one-cycle response strobe, and re-synchronises the tile's internal beat counter after every reset.

## Interface
- AW, 3, address width; must be ≤ NW; the nibble MSBs above AW are driven 0
- DW, 8, data width; fixed at 2×NW
- NW, 4, nibble width of the SRAM bus
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer when req_valid & req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  byte address
- req_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  DW  read data; holds until the next read
- sram_io_in  out  8  packed pins to the tile {nibble, oe, we, srst, sclk}
- sram_io_out  in  8  tile data output; valid while oe=1 & we=0

## Operation
- Every sram_io_in bit is driven from a flop. No combinational decode reaches the pins, so the tile clock is glitch-free.
- A beat takes two cycles:
  - _S (setup): sclk=0, fields driven.
  - _P (pulse): sclk=1, fields held.
- The tile samples on the rising edge of sclk.
- States: INIT_S, INIT_P, IDLE, W0_S, W0_P, W1_S, W1_P, WA_S, WA_P, RA_S, RA_P, RCAP.
- INIT beat: srst=1, oe=0, we=0, nibble=0. This clears the tile's counter. INIT_P → IDLE.
- IDLE:
  - Pins are 0x00 and req_ready=1.
  - On acceptance, capture req_we, req_addr and req_wdata into internal registers.
  - Write → W0_S; read → RA_S.
  - Requests that are not accepted are ignored.
- Write (we=1, oe=0, three beats):
  - W0 nibble = wdata[3:0]
  - W1 nibble = wdata[7:4]
  - WA nibble = {0, addr}
  - WA_P → IDLE.
- Read (oe=1, we=0):
  - RA beat with nibble = {0, addr}.
  - RCAP: sclk=0, oe, we and nibble held; register sram_io_out into rsp_rdata.
  - RCAP → IDLE, with rsp_valid=1 for that one IDLE cycle.
- Back-to-back: a new request can be accepted in the same IDLE cycle that rsp_valid is high.

## Timing
- Reset values:
  - sram_io_in = 0x02 (tile held in reset while the host is in reset)
  - req_ready=0, rsp_valid=0, rsp_rdata=0
  - state = INIT_S
- After reset deassertion:
  - Cycle 0 (INIT_S): pins 0x02.
  - Cycle 1 (INIT_P): pins 0x03.
  - Cycle 2 (IDLE): pins 0x00, req_ready=1.
- Write latency: accept in cycle A, beats occupy A+1..A+6, IDLE at A+7.
- Read latency:
  - RA_S at A+1, RA_P at A+2, RCAP at A+3.
  - rsp_valid at A+4, with rsp_rdata valid from A+4.
- Asynchronous reset mid-operation (any state):
  - Immediately returns all outputs to their reset values.
  - Any partial tile write is abandoned.
  - The INIT beat then realigns the tile's counter.
  - A pending read produces no rsp_valid.
- Fields change only on entry to an _S state, on the same edge sclk falls. This gives a full cycle of setup and hold around each sclk rise.
- rsp_rdata updates only in RCAP.

## Structure
- Package jar_sram_pkg holds:
  - state enum (4-bit)
  - pin bit-index constants: NIB_HI=7, NIB_LO=4, OE=3, WE=2, SRST=1, SCLK=0
  - localparams for the beat count per operation
- The tile model jar_sram_top is a bench-only sub-module: instantiate it in the testbench with io_in = sram_io_in and its io_clk tied to sram_io_in[0]. It is not part of the host RTL.
- The host is a single module. No sub-module is needed.

## Test plan
- Reset release → pins 0x02 during reset, then 0x02, 0x03, 0x00; req_ready first high 2 cycles after release.
- Write addr 5, data 0xA7 → pins 0x74, 0x75, 0xA4, 0xA5, 0x54, 0x55, 0x00; tile mem[5]=0xA7.
- Read addr 5 after that write → pins 0x58, 0x59, 0x58; rsp_valid pulse with rsp_rdata=0xA7 at A+4.
- Write 0x10+i to every addr 0..7, then read all back → each rsp_rdata=0x10+i; nibble bit 7 always 0.
- Assert rst during W1_P of a write to addr 2 → pins 0x02 asynchronously; after release, write addr 2 data 0x3C then read it → 0x3C (counter resynced).
- req_valid held high with alternating write/read → accepts only in IDLE; no beats overlap; rsp_valid coincides with req_ready; no pin change other than on entry to an _S state.
